histogram_frame_sequencer: RTL

Controller that sequences the shared histogram bin RAM of the camera pipeline across the phases of each frame:
- clear the bins;
- accumulate pixel intensities while a frame is valid;
- sweep the bins to build the cumulative sum and derive a threshold.

It sits between the CCD pixel stream and the simple-dual-port bin RAM, and feeds the threshold to the display/threshold stage.

---
 rtl/histogram_frame_sequencer_if.sv | 40 ++++
 rtl/histogram_frame_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_frame_sequencer_if.sv
// ============================================================================
// Module      : histogram_frame_sequencer_if
// Description : Pixel stream, bin RAM and result bundle of the histogram
//               frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface histogram_frame_sequencer_if #(
   parameter int BIN_BITS   = 8,
   parameter int COUNT_BITS = 19
);
   logic                  iFval;
   logic                  iDval;
   logic [BIN_BITS-1:0]   iPixel;
   logic [BIN_BITS-1:0]   oRamRaddr;
   logic [COUNT_BITS-1:0] iRamRdata;
   logic [BIN_BITS-1:0]   oRamWaddr;
   logic                  oRamWe;
   logic [COUNT_BITS-1:0] oRamWdata;
   logic [BIN_BITS-1:0]   oThreshold;
   logic                  oThreshValid;
   logic [COUNT_BITS-1:0] oPixCount;
   logic [2:0]            oPhase;
   logic                  oOverrun;

   modport master (
      input  iFval, iDval, iPixel, iRamRdata,
      output oRamRaddr, oRamWaddr, oRamWe, oRamWdata,
      output oThreshold, oThreshValid, oPixCount, oPhase, oOverrun
   );

   modport slave (
      output iFval, iDval, iPixel, iRamRdata,
      input  oRamRaddr, oRamWaddr, oRamWe, oRamWdata,
      input  oThreshold, oThreshValid, oPixCount, oPhase, oOverrun
   );
endinterface

`default_nettype wire

// File: rtl/histogram_frame_sequencer.sv
// ============================================================================
// Module      : histogram_frame_sequencer
// Description : Clears, accumulates and sweeps the shared histogram bin RAM
//               once per frame and derives a cumulative-count threshold.
//               Optional macro CUM_WRITEBACK_EN writes the running sum back
//               into the RAM during the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module histogram_frame_sequencer #(
   parameter int BIN_BITS     = 8,
   parameter int COUNT_BITS   = 19,
   parameter int TARGET_SHIFT = 1
) (
   input  wire logic iClk,
   input  wire logic iRst,
   histogram_frame_sequencer_if.master bus
);

   localparam logic [2:0] c_CLEAR    = 3'd0;
   localparam logic [2:0] c_WAIT     = 3'd1;
   localparam logic [2:0] c_ACCUM    = 3'd2;
   localparam logic [2:0] c_DRAIN    = 3'd3;
   localparam logic [2:0] c_CUMULATE = 3'd4;

   localparam int                    c_NBINS    = 1 << BIN_BITS;
   localparam logic [BIN_BITS:0]     c_LAST_BIN = (BIN_BITS+1)'(c_NBINS - 1);
   localparam logic [BIN_BITS:0]     c_SWEEP_END = (BIN_BITS+1)'(c_NBINS);
   localparam logic [COUNT_BITS-1:0] c_CNT_MAX  = '1;

   logic [2:0]            r_state;
   logic [BIN_BITS:0]     r_idx;
   logic                  r_arm;
   logic                  r_fval_d;
   logic                  r_s1_valid;
   logic [BIN_BITS-1:0]   r_s1_bin;
   logic                  r_prev_we;
   logic [BIN_BITS-1:0]   r_prev_bin;
   logic [COUNT_BITS-1:0] r_prev_data;
   logic [COUNT_BITS-1:0] r_pix_cnt;
   logic [COUNT_BITS-1:0] r_pix_count_out;
   logic [COUNT_BITS-1:0] r_target;
   logic [COUNT_BITS-1:0] r_sum;
   logic                  r_found;
   logic [BIN_BITS-1:0]   r_cand;
   logic [BIN_BITS-1:0]   r_threshold;
   logic                  r_overrun;

   logic                  w_fval_rise;
   logic                  w_start;
   logic                  w_accept;
   logic                  w_s1_fwd;
   logic [COUNT_BITS-1:0] w_s1_old;
   logic [COUNT_BITS-1:0] w_s1_new;
   logic [COUNT_BITS:0]   w_sum_wide;
   logic [COUNT_BITS-1:0] w_sum_next;
   logic                  w_sweep_data;
   logic                  w_hit;
   logic [BIN_BITS-1:0]   w_sweep_bin;
   logic                  w_final;
   logic [BIN_BITS-1:0]   w_thr_final;
   logic [BIN_BITS-1:0]   w_raddr;
   logic [BIN_BITS-1:0]   w_waddr;
   logic [COUNT_BITS-1:0] w_wdata;
   logic                  w_we;

   assign w_fval_rise = bus.iFval & ~r_fval_d;
   assign w_start     = (r_state == c_WAIT) & w_fval_rise;
   assign w_accept    = bus.iDval & (w_start | ((r_state == c_ACCUM) & bus.iFval));

   // The RAM returns stale data when the bin was written on the read edge.
   assign w_s1_fwd = r_prev_we && (r_prev_bin == r_s1_bin);
   assign w_s1_old = w_s1_fwd ? r_prev_data : bus.iRamRdata;
   assign w_s1_new = (w_s1_old == c_CNT_MAX) ? c_CNT_MAX : w_s1_old + COUNT_BITS'(1);

   assign w_sum_wide   = {1'b0, r_sum} + {1'b0, bus.iRamRdata};
   assign w_sum_next   = w_sum_wide[COUNT_BITS] ? c_CNT_MAX : w_sum_wide[COUNT_BITS-1:0];
   assign w_sweep_data = (r_state == c_CUMULATE) && (r_idx != '0);
   assign w_sweep_bin  = r_idx[BIN_BITS-1:0] - BIN_BITS'(1);
   assign w_hit        = w_sweep_data && !r_found && (w_sum_next >= r_target);
   assign w_final      = (r_state == c_CUMULATE) && (r_idx == c_SWEEP_END);
   assign w_thr_final  = r_found ? r_cand : w_sweep_bin;

   always_comb begin
      w_raddr = '0;
      w_waddr = '0;
      w_wdata = '0;
      w_we    = 1'b0;
      case (r_state)
         c_CLEAR: begin
            w_we    = r_arm;
            w_waddr = r_idx[BIN_BITS-1:0];
         end
         c_WAIT, c_ACCUM, c_DRAIN: begin
            if (w_accept) begin
               w_raddr = bus.iPixel;
            end
            if (r_s1_valid) begin
               w_we    = 1'b1;
               w_waddr = r_s1_bin;
               w_wdata = w_s1_new;
            end
         end
         c_CUMULATE: begin
            if (!r_idx[BIN_BITS]) begin
               w_raddr = r_idx[BIN_BITS-1:0];
            end
`ifdef CUM_WRITEBACK_EN
            if (w_sweep_data) begin
               w_we    = 1'b1;
               w_waddr = w_sweep_bin;
               w_wdata = w_sum_next;
            end
`endif
         end
         default: begin
            w_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state         <= c_CLEAR;
         r_idx           <= '0;
         r_arm           <= 1'b0;
         r_fval_d        <= 1'b0;
         r_s1_valid      <= 1'b0;
         r_s1_bin        <= '0;
         r_prev_we       <= 1'b0;
         r_prev_bin      <= '0;
         r_prev_data     <= '0;
         r_pix_cnt       <= '0;
         r_pix_count_out <= '0;
         r_target        <= '0;
         r_sum           <= '0;
         r_found         <= 1'b0;
         r_cand          <= '0;
         r_threshold     <= '0;
         r_overrun       <= 1'b0;
      end else begin
         r_fval_d    <= bus.iFval;
         r_s1_valid  <= w_accept;
         r_s1_bin    <= bus.iPixel;
         r_prev_we   <= r_s1_valid;
         r_prev_bin  <= r_s1_bin;
         r_prev_data <= w_s1_new;

         if (w_fval_rise && (r_state != c_WAIT)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            c_CLEAR: begin
               // One idle cycle after reset keeps the write strobe low while
               // the outputs still show their reset values.
               if (!r_arm) begin
                  r_arm <= 1'b1;
               end else if (r_idx == c_LAST_BIN) begin
                  r_idx   <= '0;
                  r_state <= c_WAIT;
               end else begin
                  r_idx <= r_idx + (BIN_BITS+1)'(1);
               end
            end
            c_WAIT: begin
               if (w_start) begin
                  r_pix_cnt <= {{(COUNT_BITS-1){1'b0}}, w_accept};
                  r_state   <= c_ACCUM;
               end
            end
            c_ACCUM: begin
               if (!bus.iFval) begin
                  r_state <= c_DRAIN;
               end else if (w_accept && (r_pix_cnt != c_CNT_MAX)) begin
                  r_pix_cnt <= r_pix_cnt + COUNT_BITS'(1);
               end
            end
            c_DRAIN: begin
               r_pix_count_out <= r_pix_cnt;
               r_target        <= r_pix_cnt >> TARGET_SHIFT;
               r_sum           <= '0;
               r_found         <= 1'b0;
               r_idx           <= '0;
               r_state         <= c_CUMULATE;
            end
            c_CUMULATE: begin
               if (w_sweep_data) begin
                  r_sum <= w_sum_next;
               end
               if (w_hit) begin
                  r_found <= 1'b1;
                  r_cand  <= w_sweep_bin;
               end
               if (w_final) begin
                  r_threshold <= w_thr_final;
                  r_idx       <= '0;
                  r_state     <= c_CLEAR;
               end else begin
                  r_idx <= r_idx + (BIN_BITS+1)'(1);
               end
            end
            default: begin
               r_idx   <= '0;
               r_state <= c_CLEAR;
            end
         endcase
      end
   end

   assign bus.oRamRaddr    = w_raddr;
   assign bus.oRamWaddr    = w_waddr;
   assign bus.oRamWdata    = w_wdata;
   assign bus.oRamWe       = w_we;
   // The threshold is presented on the same cycle as its valid pulse.
   assign bus.oThreshold   = w_final ? w_thr_final : r_threshold;
   assign bus.oThreshValid = w_final;
   assign bus.oPixCount    = r_pix_count_out;
   assign bus.oPhase       = r_state;
   assign bus.oOverrun     = r_overrun;

endmodule

`default_nettype wire
